// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit 7-segment panel that
// shares a single hexa7seg decoder among N_DIGITS digits.
//
// A packed hex word is double-buffered. carga captures it into a shadow
// buffer. The digits always show the front buffer, which is refreshed from
// the shadow only at a frame boundary, so a frame never mixes old and new
// data. The FSM lights one digit at a time for TICK_DIV cycles. Between
// digits it inserts GUARD_CYCLES all-off cycles so that the previous
// digit's segments do not ghost onto the next one.
//
// Parameters
//   N_DIGITS      number of digits scanned (>= 2)
//   TICK_DIV      cycles each digit is lit (>= 2)
//   GUARD_CYCLES  all-off cycles between digits (0 = no guard slot)
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   enable      in   1 = scan runs, 0 = all digits off (returns to IDLE)
//   carga       in   1-cycle strobe: capture dado into the shadow buffer
//   dado        in   packed hex digits, nibble i -> digit i
//   blank_mask  in   bit i = 1 forces digit i dark (its slot is still timed)
//   hexa        out  nibble for the shared decoder (front nibble of idx)
//   sseg_in     in   decoder result, active-low, bit 6 = segment g
//   seg         out  segment bus to the panel, active-low
//   an          out  digit enables, active-low one-hot (registered)
//   fim_quadro  out  1-cycle pulse in the cycle after each frame wrap
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          (digit 0 never is). blank_mask still applies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module display_scan_ctrl #(
  parameter int N_DIGITS     = 6,
  parameter int TICK_DIV     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    carga,
  input  logic [4*N_DIGITS-1:0]   dado,
  input  logic [N_DIGITS-1:0]     blank_mask,
  output logic [3:0]              hexa,
  input  logic [6:0]              sseg_in,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    fim_quadro
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (TICK_DIV > GUARD_CYCLES) ? TICK_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GUARD  = 2'd2
  } state_t;

  state_t                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [CNT_W-1:0]         div_q;       // slot counter, reused for the guard slot
  logic [4*N_DIGITS-1:0]    shadow_q;
  logic [4*N_DIGITS-1:0]    front_q;
  logic                     pending_q;
  logic                     fim_q;
  logic [N_DIGITS-1:0]      an_q;

  logic [IDX_W-1:0]         idx_d;
  logic                     frame_wrap;
  logic [N_DIGITS-1:0]      lz_blank;
  logic [N_DIGITS-1:0]      blank_eff;
  logic                     cur_blank;

  // Active-low one-hot enable pattern for digit i.
  function automatic logic [N_DIGITS-1:0] an_for(input logic [IDX_W-1:0] i);
    logic [N_DIGITS-1:0] v;
    v = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (i == IDX_W'(k)) v[k] = 1'b0;
    end
    return v;
  endfunction

  assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // The last lit cycle of the last digit. A dropped enable takes priority,
  // so a frame that is aborted never counts as wrapped.
  assign frame_wrap = enable && (state_q == S_ACTIVE) &&
                      (div_q == TICK_LAST) && (idx_q == IDX_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      shadow_q  <= '0;
      front_q   <= '0;
      pending_q <= 1'b0;
      fim_q     <= 1'b0;
      an_q      <= '1;
    end else begin
      fim_q <= frame_wrap;

      // A load that lands exactly on the wrap goes straight to the front,
      // so nothing stays pending for a whole extra frame.
      if (frame_wrap) begin
        pending_q <= 1'b0;
        if (carga) begin
          front_q  <= dado;
          shadow_q <= dado;
        end else if (pending_q) begin
          front_q <= shadow_q;
        end
      end else if (carga) begin
        shadow_q  <= dado;
        pending_q <= 1'b1;
      end

      if (!enable) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
        div_q   <= '0;
        an_q    <= '1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_ACTIVE;
            idx_q   <= '0;
            div_q   <= '0;
            an_q    <= an_for('0);
          end
          S_ACTIVE: begin
            if (div_q == TICK_LAST) begin
              idx_q <= idx_d;
              div_q <= '0;
              if (GUARD_CYCLES == 0) begin
                state_q <= S_ACTIVE;
                an_q    <= an_for(idx_d);
              end else begin
                state_q <= S_GUARD;
                an_q    <= '1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          S_GUARD: begin
            if (div_q == GUARD_LAST) begin
              state_q <= S_ACTIVE;
              div_q   <= '0;
              an_q    <= an_for(idx_q);
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            an_q    <= '1;
          end
        endcase
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit. A digit is a leading zero
  // while every nibble from the top down to it is zero. Digit 0 is excluded
  // so that a value of zero still shows a single "0".
  always_comb begin
    logic zero_run;
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (front_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign blank_eff = blank_mask | lz_blank;

  // Select the current digit's nibble and blank flag.
  always_comb begin
    hexa      = front_q[3:0];
    cur_blank = blank_eff[0];
    for (int i = 1; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        hexa      = front_q[4*i +: 4];
        cur_blank = blank_eff[i];
      end
    end
  end

  assign seg        = ((state_q == S_ACTIVE) && !cur_blank) ? sseg_in : 7'h7F;
  assign an         = an_q;
  assign fim_quadro = fim_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps

module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int GC = 1;
  localparam int FRAME = N * (TD + GC);

  // Expected active-low segment patterns per digit, packed {d3,d2,d1,d0}.
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] SEG_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] SEG_00F0  = {7'h7F, 7'h7F, 7'h0E, 7'h40};
  localparam logic [27:0] SEG_00F0B = {7'h7F, 7'h7F, 7'h0E, 7'h40};
`else
  localparam logic [27:0] SEG_ZERO  = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEG_00F0  = {7'h40, 7'h40, 7'h0E, 7'h40};
  localparam logic [27:0] SEG_00F0B = {7'h40, 7'h7F, 7'h0E, 7'h40};
`endif
  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};

  logic        clock;
  logic        reset;
  logic        enable;
  logic        carga;
  logic [15:0] dado;
  logic [3:0]  blank_mask;
  logic [3:0]  hexa;
  logic [6:0]  sseg_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        fim_quadro;

  int checks   = 0;
  int failures = 0;

  display_scan_ctrl #(
    .N_DIGITS    (N),
    .TICK_DIV    (TD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .carga      (carga),
    .dado       (dado),
    .blank_mask (blank_mask),
    .hexa       (hexa),
    .sseg_in    (sseg_in),
    .seg        (seg),
    .an         (an),
    .fim_quadro (fim_quadro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the shared hexa7seg decoder (active-low, bit 6 = g).
  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  always_comb sseg_in = dec7(hexa);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] ehexa);
    chk({tag, "_an"},   32'(an),         32'(4'hF));
    chk({tag, "_seg"},  32'(seg),        32'(7'h7F));
    chk({tag, "_fim"},  32'(fim_quadro), 32'(1'b0));
    chk({tag, "_hexa"}, 32'(hexa),       32'(ehexa));
    $display("idle %s an=%b seg=%h fim=%b hexa=%h", tag, an, seg, fim_quadro, hexa);
  endtask

  // Walks one full frame starting at digit 0's first lit cycle.
  // Optionally strobes carga with cdado during local cycle carga_at.
  task automatic check_frame(input string tag, input logic [15:0] ehexa,
                             input logic [27:0] eseg, input int carga_at,
                             input logic [15:0] cdado);
    int d;
    int ph;
    logic [3:0] ean;
    for (int c = 0; c < FRAME; c++) begin
      d  = c / (TD + GC);
      ph = c % (TD + GC);
      if (ph < TD) begin
        ean = ~(4'b0001 << d);
        chk($sformatf("%s_c%0d_an", tag, c),   32'(an),         32'(ean));
        chk($sformatf("%s_c%0d_hexa", tag, c), 32'(hexa),       32'(ehexa[4*d +: 4]));
        chk($sformatf("%s_c%0d_seg", tag, c),  32'(seg),        32'(eseg[7*d +: 7]));
        chk($sformatf("%s_c%0d_fim", tag, c),  32'(fim_quadro), 32'(1'b0));
      end else begin
        chk($sformatf("%s_c%0d_an", tag, c),   32'(an),         32'(4'hF));
        chk($sformatf("%s_c%0d_seg", tag, c),  32'(seg),        32'(7'h7F));
        chk($sformatf("%s_c%0d_fim", tag, c),  32'(fim_quadro), 32'(d == N - 1));
      end
      if (ph == 0) $display("frame %s digit=%0d an=%b hexa=%h seg=%h", tag, d, an, hexa, seg);
      if (c == carga_at) begin
        carga = 1'b1;
        dado  = cdado;
      end
      tick();
      carga = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    carga      = 1'b0;
    dado       = 16'h0000;
    blank_mask = 4'b0000;

    // Reset held for two cycles.
    tick();
    check_idle("reset1", 4'h0);
    tick();
    check_idle("reset2", 4'h0);
    reset = 1'b0;

    // Load 1234 while idle; it waits in the shadow until the first wrap.
    carga = 1'b1;
    dado  = 16'h1234;
    tick();
    carga = 1'b0;
    check_idle("loaded", 4'h0);
    enable = 1'b1;
    tick();

    check_frame("f1_front0", 16'h0000, SEG_ZERO, -1, 16'h0000);
    check_frame("f2_1234",   16'h1234, SEG_1234, -1, 16'h0000);
    // Mid-frame load must not tear the frame in progress.
    check_frame("f3_midload", 16'h1234, SEG_1234, 5, 16'hABCD);
    // Load exactly on the wrap edge goes straight to the front.
    check_frame("f4_abcd",   16'hABCD, SEG_ABCD, FRAME - GC - 1, 16'h00F0);
    check_frame("f5_00f0",   16'h00F0, SEG_00F0, -1, 16'h0000);

    // Blank digit 2: slot timing kept, segments dark.
    blank_mask = 4'b0100;
    check_frame("f6_blank2", 16'h00F0, SEG_00F0B, -1, 16'h0000);
    blank_mask = 4'b0000;

    // Drop enable in the middle of digit 1's slot.
    for (int c = 0; c < TD + GC + 1; c++) tick();
    chk("pre_drop_an", 32'(an), 32'(4'b1101));
    enable = 1'b0;
    tick();
    check_idle("drop1", 4'h0);
    tick();
    check_idle("drop2", 4'h0);
    enable = 1'b1;
    tick();
    check_frame("f7_reenable", 16'h00F0, SEG_00F0, -1, 16'h0000);

    // Reset mid-scan together with a carga: reset must win.
    tick();
    tick();
    reset = 1'b1;
    carga = 1'b1;
    dado  = 16'h5555;
    tick();
    reset = 1'b0;
    carga = 1'b0;
    check_idle("midreset", 4'h0);
    tick();
    check_frame("f8_after_reset", 16'h0000, SEG_ZERO, -1, 16'h0000);
    check_frame("f9_no_pending",  16'h0000, SEG_ZERO, -1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
